uart_rx_fifo: RTL and testbench

Parametrised UART receiver with integrated FIFO and valid/ready output; the next generation of the receiver-plus-single-entry-buffer pair. Oversamples rx at 16x and supports configurable data width and FIFO depth. Reports framing errors and overrun as sticky-free pulses. Sits between the external rx pin and any valid/ready consumer (APB bridge, DMA).

---
 rtl/uart_rx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver feeding a first-word-fall-through FIFO with valid/ready output.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined (sense chosen by PARITY_ODD).
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_DIV   = 27
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 en,
  input  logic                                 rx,
  output logic [DATA_BITS-1:0]                 data_o,
  output logic                                 valid_out,
  input  logic                                 ready_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      level,
  output logic                                 rx_busy,
  output logic                                 frame_err,
  output logic                                 overrun,
  output logic                                 parity_err
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                 sync1_reg;
  logic                 rx_s_reg;
  logic [2:0]           state_reg;
  logic [BW-1:0]        bcnt_reg;
  logic [3:0]           tcnt_reg;
  logic [IW-1:0]        bidx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 push_reg;
  logic [DATA_BITS-1:0] push_data_reg;
  logic                 frame_err_reg;
  logic                 parity_err_reg;
  logic                 overrun_reg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_reg;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [LW-1:0]        level_reg;
  logic [DATA_BITS-1:0] data_reg;

  logic          tick;
  logic          full;
  logic          empty;
  logic          do_pop;
  logic          do_push;
  logic [PW-1:0] rd_next;

  // Baud counter only runs while a frame is in progress, so the first tick lands BAUD_DIV cycles after start detect
  assign tick    = (state_reg != ST_IDLE) && (bcnt_reg == BW'(BAUD_DIV - 1));
  assign full    = (level_reg == LW'(FIFO_DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = !empty && ready_out;
  assign do_push = push_reg && (!full || do_pop);
  assign rd_next = rd_ptr_reg + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_reg <= 1'b1;
      rx_s_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rx_s_reg  <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      bcnt_reg       <= '0;
      tcnt_reg       <= '0;
      bidx_reg       <= '0;
      shift_reg      <= '0;
      push_reg       <= 1'b0;
      push_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
`endif
    end else begin
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      push_reg       <= 1'b0;
      if (state_reg == ST_IDLE || tick) bcnt_reg <= '0;
      else                              bcnt_reg <= bcnt_reg + 1'b1;
      if (tick) tcnt_reg <= tcnt_reg + 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (en && !rx_s_reg) begin
            state_reg <= ST_START;
            tcnt_reg  <= '0;
          end
        end
        ST_START: begin
          if (tick && tcnt_reg == 4'd7) begin
            if (rx_s_reg) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_DATA;
              tcnt_reg  <= '0;
              bidx_reg  <= '0;
            end
          end
        end
        ST_DATA: begin
          if (tick && tcnt_reg == 4'd15) begin
            shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
            if (bidx_reg == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= ST_PARITY;
`else
              state_reg <= ST_STOP;
`endif
            end else begin
              bidx_reg <= bidx_reg + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick && tcnt_reg == 4'd15) begin
            par_bad_reg <= ((^shift_reg) ^ rx_s_reg) != 1'(PARITY_ODD);
            state_reg   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick && tcnt_reg == 4'd15) begin
            state_reg <= ST_IDLE;
            if (!rx_s_reg) begin
              frame_err_reg <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_reg) begin
              parity_err_reg <= 1'b1;
`endif
            end else begin
              push_reg      <= 1'b1;
              push_data_reg <= shift_reg;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data_reg;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= push_reg && full && !do_pop;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_next;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      // The head slot is being written this cycle when the FIFO is empty or its last entry is leaving
      if (do_push && (empty || (do_pop && level_reg == LW'(1)))) data_reg <= push_data_reg;
      else if (do_pop && level_reg > LW'(1))                     data_reg <= mem[rd_next];
    end
  end

  assign data_o     = data_reg;
  assign valid_out  = !empty;
  assign level      = level_reg;
  assign rx_busy    = (state_reg != ST_IDLE);
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign parity_err = parity_err_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=4, FIFO_DEPTH=4, 8 data bits (64 clk per bit).
// Define UART_RX_PARITY_EN for both RTL and bench to exercise the even-parity build.
module tb_uart_rx_fifo;
  localparam int DB  = 8;
  localparam int DEP = 4;
  localparam int BD  = 4;
  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       ready_out = 1'b0;
  logic [7:0] data_o;
  logic       valid_out;
  logic [2:0] level;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_fail = 0;

  int fe_cyc = 0;
  int ov_cyc = 0;
  int pe_cyc = 0;
  int valid_cyc = 0;
  int pop_cnt = 0;
  logic [7:0] last_pop = 8'h00;

  uart_rx_fifo #(
    .DATA_BITS (DB),
    .FIFO_DEPTH(DEP),
    .BAUD_DIV  (BD)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .rx        (rx),
    .data_o    (data_o),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .level     (level),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err)  fe_cyc    <= fe_cyc + 1;
    if (overrun)    ov_cyc    <= ov_cyc + 1;
    if (parity_err) pe_cyc    <= pe_cyc + 1;
    if (valid_out)  valid_cyc <= valid_cyc + 1;
    if (valid_out && ready_out) begin
      pop_cnt  <= pop_cnt + 1;
      last_pop <= data_o;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    logic p;
    p = (^d) ^ par_flip;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = p;
    repeat (BIT) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    int bad;
    rstn = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data_o !== 8'h00)  begin n_fail++; $display("FAIL reset_data_o: got %h expected 00", data_o); end
    n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_checks++; if (level !== 3'd0)     begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (rx_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    n_checks++; if ({frame_err, overrun, parity_err} !== 3'b000)
      begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err}); end
    rstn = 1'b1;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({valid_out, level, rx_busy, frame_err, overrun, parity_err} !== 8'h00) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_1000: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_enable;
    int pc0;
    int bsy;
    en = 1'b0;
    rx = 1'b0;
    bsy = 0;
    repeat (20) begin
      @(negedge clk);
      if (rx_busy) bsy++;
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;
    n_checks++; if (bsy != 0) begin n_fail++; $display("FAIL en_gate: got %0d busy cycles expected 0", bsy); end
    // Dropping en mid-frame must not abort the frame in progress
    ready_out = 1'b1;
    pc0 = pop_cnt;
    fork
      send_frame(8'h96, 1'b1, 1'b0);
      begin repeat (100) @(negedge clk); en = 1'b0; end
    join
    repeat (10) @(negedge clk);
    en = 1'b1;
    n_checks++; if (pop_cnt - pc0 != 1) begin n_fail++; $display("FAIL en_midframe_count: got %0d expected 1", pop_cnt - pc0); end
    n_checks++; if (last_pop !== 8'h96) begin n_fail++; $display("FAIL en_midframe_data: got %h expected 96", last_pop); end
  endtask

  task automatic test_single_byte;
    int vc0;
    int pc0;
    ready_out = 1'b1;
    vc0 = valid_cyc;
    pc0 = pop_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++; if (valid_cyc - vc0 != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d expected 1", valid_cyc - vc0); end
    n_checks++; if (pop_cnt - pc0 != 1)   begin n_fail++; $display("FAIL single_pops: got %0d expected 1", pop_cnt - pc0); end
    n_checks++; if (last_pop !== 8'hA5)   begin n_fail++; $display("FAIL single_data: got %h expected a5", last_pop); end
    n_checks++; if (level !== 3'd0)       begin n_fail++; $display("FAIL single_level: got %0d expected 0", level); end
  endtask

  task automatic test_glitch;
    int fe0;
    int pe0;
    int vc0;
    logic seen;
    fe0 = fe_cyc; pe0 = pe_cyc; vc0 = valid_cyc;
    seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 9) seen = rx_busy;
    end
    rx = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (seen !== 1'b1)    begin n_fail++; $display("FAIL glitch_detect: got busy=%b expected 1", seen); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got busy=%b expected 0", rx_busy); end
    n_checks++; if ((fe_cyc - fe0) + (pe_cyc - pe0) != 0)
      begin n_fail++; $display("FAIL glitch_err: got %0d error cycles expected 0", (fe_cyc - fe0) + (pe_cyc - pe0)); end
    n_checks++; if (valid_cyc != vc0) begin n_fail++; $display("FAIL glitch_push: got %0d valid cycles expected 0", valid_cyc - vc0); end
  endtask

  task automatic test_framing;
    int fe0;
    int pc0;
    ready_out = 1'b1;
    fe0 = fe_cyc; pc0 = pop_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    n_checks++; if (fe_cyc - fe0 != 1) begin n_fail++; $display("FAIL framing_pulse: got %0d cycles expected 1", fe_cyc - fe0); end
    n_checks++; if (pop_cnt != pc0)    begin n_fail++; $display("FAIL framing_push: got %0d pops expected 0", pop_cnt - pc0); end
    n_checks++; if (level !== 3'd0)    begin n_fail++; $display("FAIL framing_level: got %0d expected 0", level); end
    n_checks++; if (rx_busy !== 1'b0)  begin n_fail++; $display("FAIL framing_idle: got busy=%b expected 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    ready_out = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (level !== 3'd2)    begin n_fail++; $display("FAIL b2b_level: got %0d expected 2", level); end
    n_checks++; if (data_o !== 8'h5A)  begin n_fail++; $display("FAIL b2b_head0: got %h expected 5a", data_o); end
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    n_checks++; if (data_o !== 8'hC3)  begin n_fail++; $display("FAIL b2b_head1: got %h expected c3", data_o); end
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    n_checks++; if (valid_out !== 1'b0 || level !== 3'd0)
      begin n_fail++; $display("FAIL b2b_empty: got valid=%b level=%0d expected 0/0", valid_out, level); end
  endtask

  task automatic test_overrun;
    int ov0;
    ready_out = 1'b0;
    ov0 = ov_cyc;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (level !== 3'd4)  begin n_fail++; $display("FAIL ovr_full_level: got %0d expected 4", level); end
    n_checks++; if (ov_cyc != ov0)   begin n_fail++; $display("FAIL ovr_early: got %0d cycles expected 0", ov_cyc - ov0); end
    send_frame(8'h05, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (ov_cyc - ov0 != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ov_cyc - ov0); end
    n_checks++; if (level !== 3'd4)     begin n_fail++; $display("FAIL ovr_level: got %0d expected 4", level); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if (valid_out !== 1'b1 || data_o !== 8'(i))
        begin n_fail++; $display("FAIL ovr_drain%0d: got valid=%b data=%h expected 1/%h", i, valid_out, data_o, 8'(i)); end
      ready_out = 1'b1;
      @(negedge clk);
      ready_out = 1'b0;
    end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL ovr_drained: got %0d expected 0", level); end
  endtask

  task automatic test_overrun_with_pop;
    int ov0;
    int n;
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    ov0 = ov_cyc;
    n = 0;
    fork
      send_frame(8'h15, 1'b1, 1'b0);
      begin
        while (!rx_busy && n < 2000) begin @(negedge clk); n++; end
        while (rx_busy && n < 2000) begin @(negedge clk); n++; end
        // First idle negedge after the stop sample is the push cycle
        ready_out = 1'b1;
        @(negedge clk);
        ready_out = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    n_checks++; if (n >= 2000)      begin n_fail++; $display("FAIL ovp_timeout: got %0d cycles expected <2000", n); end
    n_checks++; if (ov_cyc != ov0)  begin n_fail++; $display("FAIL ovp_no_overrun: got %0d cycles expected 0", ov_cyc - ov0); end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovp_level: got %0d expected 4", level); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (valid_out !== 1'b1 || data_o !== 8'h12 + 8'(i))
        begin n_fail++; $display("FAIL ovp_drain%0d: got valid=%b data=%h expected 1/%h", i, valid_out, data_o, 8'h12 + 8'(i)); end
      ready_out = 1'b1;
      @(negedge clk);
      ready_out = 1'b0;
    end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL ovp_drained: got %0d expected 0", level); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int pe0;
    ready_out = 1'b0;
    pe0 = pe_cyc;
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (level !== 3'd1)  begin n_fail++; $display("FAIL par_good_level: got %0d expected 1", level); end
    n_checks++; if (pe_cyc != pe0)   begin n_fail++; $display("FAIL par_good_err: got %0d cycles expected 0", pe_cyc - pe0); end
    n_checks++; if (data_o !== 8'h07) begin n_fail++; $display("FAIL par_good_data: got %h expected 07", data_o); end
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    n_checks++; if (pe_cyc - pe0 != 1) begin n_fail++; $display("FAIL par_bad_pulse: got %0d cycles expected 1", pe_cyc - pe0); end
    n_checks++; if (level !== 3'd1)    begin n_fail++; $display("FAIL par_bad_level: got %0d expected 1", level); end
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
  endtask
`endif

  task automatic test_midframe_reset;
    ready_out = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL mfr_pre_level: got %0d expected 1", level); end
    rx = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL mfr_busy: got %b expected 1", rx_busy); end
    rstn = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    n_checks++; if (level !== 3'd0 || valid_out !== 1'b0)
      begin n_fail++; $display("FAIL mfr_flush: got level=%0d valid=%b expected 0/0", level, valid_out); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mfr_abort: got %b expected 0", rx_busy); end
    n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL mfr_data: got %h expected 00", data_o); end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_enable();
    test_single_byte();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_overrun();
    test_overrun_with_pop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`else
    n_checks++; if (pe_cyc != 0) begin n_fail++; $display("FAIL parity_tied: got %0d cycles expected 0", pe_cyc); end
`endif
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
